// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers used by the decryption datapath.
package aes_pkg;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  // Low byte of the field polynomial x^8+x^4+x^3+x+1.
  localparam aes_byte_t AES_RED = 8'h1B;

  function automatic aes_byte_t xtime(input aes_byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_RED : 8'h00);
  endfunction

  function automatic aes_byte_t gmul09(input aes_byte_t x);
    aes_byte_t x8;
    x8 = xtime(xtime(xtime(x)));
    return x8 ^ x;
  endfunction

  function automatic aes_byte_t gmul0b(input aes_byte_t x);
    aes_byte_t x2;
    aes_byte_t x8;
    x2 = xtime(x);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ x;
  endfunction

  function automatic aes_byte_t gmul0d(input aes_byte_t x);
    aes_byte_t x4;
    aes_byte_t x8;
    x4 = xtime(xtime(x));
    x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic aes_byte_t gmul0e(input aes_byte_t x);
    aes_byte_t x2;
    aes_byte_t x4;
    aes_byte_t x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// InvMixColumns on one 32-bit column; a0 is the most significant byte.
module inv_mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] new_col
);

  aes_byte_t a0, a1, a2, a3;
  aes_byte_t b0, b1, b2, b3;

  assign {a0, a1, a2, a3} = col;

  assign b0 = gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3);
  assign b1 = gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3);
  assign b2 = gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3);
  assign b3 = gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3);

  assign new_col = {b0, b1, b2, b3};

endmodule

// File: rtl/aes_core.sv
// Zero-latency InvMixColumns stage; clk, rst and round_key are kept for
// pipeline drop-in compatibility and do not reach the output.
module aes_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block
);

  // Sink for the reserved ports so they stay on the interface without logic.
  logic unused_inputs;
  assign unused_inputs = ^{clk, rst, round_key};

  for (genvar c = 0; c < 4; c++) begin : g_col
    inv_mix_column_word u_col (
      .col     (block[127-32*c -: 32]),
      .new_col (new_block[127-32*c -: 32])
    );
  end

endmodule

// File: tb/tb_aes_core.sv
// Directed and round-trip checks for the InvMixColumns stage.
module tb_aes_core;

  logic         clk;
  logic         rst;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;

  int checks;
  int errors;

  aes_core dut (
    .clk       (clk),
    .rst       (rst),
    .round_key (round_key),
    .block     (block),
    .new_block (new_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent forward MixColumns model for the round-trip test.
  function automatic logic [7:0] m2(input logic [7:0] x);
    m2 = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
  endfunction

  function automatic logic [7:0] m3(input logic [7:0] x);
    m3 = m2(x) ^ x;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    mix_col = {m2(a0) ^ m3(a1) ^ a2 ^ a3,
               a0 ^ m2(a1) ^ m3(a2) ^ a3,
               a0 ^ a1 ^ m2(a2) ^ m3(a3),
               m3(a0) ^ a1 ^ a2 ^ m2(a3)};
  endfunction

  function automatic logic [127:0] mix_block(input logic [127:0] b);
    mix_block = {mix_col(b[127:96]), mix_col(b[95:64]),
                 mix_col(b[63:32]), mix_col(b[31:0])};
  endfunction

  task automatic check(input string tag, input logic [127:0] exp);
    checks++;
    assert (new_block === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, new_block, exp);
    end
  endtask

  task automatic step(input string tag, input logic [127:0] b, input logic [127:0] exp);
    @(posedge clk);
    block = b;
    @(negedge clk);
    check(tag, exp);
  endtask

  initial begin
    logic [127:0] x;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    round_key = '0;
    block     = '0;

    // Output follows block even while reset is asserted.
    #1;
    block = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    #1;
    check("during_reset", 128'hdb135345_f20a225c_01010101_c6c6c6c6);
    @(negedge clk);
    rst = 1'b0;

    step("fips_col0", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
         128'hdb135345_f20a225c_01010101_c6c6c6c6);
    step("fips_cols", 128'h4d7ebdf8_d5d5d7d6_8e4da1bc_9fdc589d,
         128'h2d26314c_d4d4d4d5_db135345_f20a225c);
    step("all_zero", '0, '0);
    step("all_ff", {128{1'b1}}, {128{1'b1}});

    // Timing: new value driven at posedge already correct at the next negedge.
    @(posedge clk);
    block = 128'h01010101_c6c6c6c6_8e4da1bc_4d7ebdf8;
    @(negedge clk);
    check("half_cycle", 128'h01010101_c6c6c6c6_db135345_2d26314c);

    // Round key at X/Z and reset toggled mid-stream must not disturb output.
    round_key = 'x;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      block = {4{32'h8e4da1bc}};
      if (i == 2) rst = 1'b1;
      if (i == 3) round_key = 'z;
      if (i == 5) rst = 1'b0;
      #2;
      if (i == 6) rst = 1'b1;
      @(negedge clk);
      check($sformatf("key_xz_rst_%0d", i), {4{32'h db135345}});
    end
    rst = 1'b0;

    // Round-trip InvMixColumns(MixColumns(x)) == x.
    for (int i = 0; i < 88; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      round_key = {$urandom, $urandom, $urandom, $urandom};
      step($sformatf("roundtrip_%0d", i), mix_block(x), x);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
